// File: rtl/checkpoint_free_list_pkg.sv
// Shared types and default sizes for the checkpointed
// physical-register free list.
package checkpoint_free_list_pkg;

  localparam int NUM_PHYREGS_DEF = 96;
  localparam int NUM_LOGREGS_DEF = 32;
  localparam int NUM_CKPT_DEF    = 8;

  typedef logic [$clog2(NUM_PHYREGS_DEF)-1:0] phyreg_idx_t;
  typedef logic [$clog2(NUM_CKPT_DEF)-1:0]    ckpt_id_t;

endpackage

// File: rtl/checkpoint_free_list_prio_pick_n.sv
// Picks the N lowest set bits of a vector, ascending,
// each with a valid flag.
module prio_pick_n #(
  parameter int N     = 4,
  parameter int WIDTH = 96,
  localparam int IW   = $clog2(WIDTH)
) (
  input  logic [WIDTH-1:0] vec,
  output logic [IW-1:0]    idx [N],
  output logic [N-1:0]     valid
);

  logic [WIDTH-1:0] m;

  always_comb begin
    m = vec;
    valid = '0;
    for (int s = 0; s < N; s++) begin
      idx[s] = '0;
      for (int b = WIDTH - 1; b >= 0; b--) begin
        if (m[b]) begin
          idx[s] = IW'(b);
          valid[s] = 1'b1;
        end
      end
      if (valid[s]) m[idx[s]] = 1'b0;
    end
  end

endmodule

// File: rtl/checkpoint_free_list.sv
// Free list with per-branch allocation masks for
// single-cycle mispredict recovery.
module checkpoint_free_list
  import checkpoint_free_list_pkg::*;
#(
  parameter int NUM_PHYREGS = NUM_PHYREGS_DEF,
  parameter int NUM_LOGREGS = NUM_LOGREGS_DEF,
  parameter int ALLOC_WIDTH = 4,
  parameter int FREE_WIDTH  = 4,
  parameter int NUM_CKPT    = NUM_CKPT_DEF,
  localparam int PW  = $clog2(NUM_PHYREGS),
  localparam int CW  = $clog2(NUM_CKPT),
  localparam int FCW = $clog2(NUM_PHYREGS + 1)
) (
  input  logic                   clock,
  input  logic                   reset,
  output logic [PW-1:0]          available_prd [ALLOC_WIDTH],
  output logic [ALLOC_WIDTH-1:0] available_valid,
  input  logic [ALLOC_WIDTH-1:0] prd_used,
  input  logic [FREE_WIDTH-1:0]  committed_rd_valid,
  input  logic [PW-1:0]          committed_phyreg [FREE_WIDTH],
  input  logic [PW-1:0]          committed_prev_phyreg [FREE_WIDTH],
  input  logic                   ckpt_take,
  output logic [CW-1:0]          ckpt_id,
  output logic                   ckpt_full,
  input  logic                   ckpt_release,
  input  logic                   ckpt_restore,
  input  logic [CW-1:0]          ckpt_restore_id,
  input  logic                   flush_in,
  output logic [FCW-1:0]         free_count
);

  typedef logic [NUM_PHYREGS-1:0] vec_t;

  localparam vec_t RESET_FL =
    {NUM_PHYREGS{1'b1}} << NUM_LOGREGS;

  vec_t fl, rfl;
  vec_t fl_next, rfl_next;
  vec_t alloc_mask, free_mask, pick_vec;
  vec_t amask [NUM_CKPT];

  logic [CW-1:0] head, tail;
  logic [CW-1:0] head_rel, head_next, tail_next;
  logic [CW:0]   cnt, cnt_next;
  logic [FCW-1:0] fl_pop;

  logic [NUM_CKPT-1:0]    live;
  logic [PW-1:0]          pick_idx [ALLOC_WIDTH];
  logic [ALLOC_WIDTH-1:0] pick_valid;
  logic kill, do_take, do_rel;

  assign pick_vec = fl & ~vec_t'(1);

  prio_pick_n #(
    .N     (ALLOC_WIDTH),
    .WIDTH (NUM_PHYREGS)
  ) u_pick (
    .vec   (pick_vec),
    .idx   (pick_idx),
    .valid (pick_valid)
  );

  assign kill = ckpt_restore | flush_in;
  assign available_prd = pick_idx;
  assign available_valid =
    pick_valid & {ALLOC_WIDTH{~kill}};
  assign ckpt_id = tail;
  assign ckpt_full = cnt == (CW+1)'(NUM_CKPT);

  always_comb begin
    for (int i = 0; i < NUM_CKPT; i++)
      live[i] = {1'b0, CW'(i) - head} < cnt;
  end

  always_comb begin
    alloc_mask = '0;
    for (int s = 0; s < ALLOC_WIDTH; s++)
      if (prd_used[s] && pick_valid[s])
        alloc_mask[pick_idx[s]] = 1'b1;
    free_mask = '0;
    rfl_next = rfl;
    for (int s = 0; s < FREE_WIDTH; s++) begin
      if (committed_rd_valid[s]) begin
        free_mask[committed_prev_phyreg[s]] = 1'b1;
        rfl_next[committed_prev_phyreg[s]] = 1'b1;
        rfl_next[committed_phyreg[s]] = 1'b0;
      end
    end
  end

  // Release moves head before a same-cycle restore sizes the ring.
  always_comb begin
    do_take = ckpt_take && !ckpt_full;
    do_rel = ckpt_release && (cnt != '0);
    head_rel = head + CW'(do_rel);
    head_next = head_rel;
    tail_next = tail;
    cnt_next = cnt;
    fl_next = (fl & ~alloc_mask) | free_mask;
    if (flush_in) begin
      fl_next = rfl_next;
      head_next = '0;
      tail_next = '0;
      cnt_next = '0;
    end else if (ckpt_restore) begin
      fl_next = fl | amask[ckpt_restore_id] | free_mask;
      tail_next = ckpt_restore_id;
      cnt_next = {1'b0, ckpt_restore_id - head_rel};
    end else begin
      tail_next = tail + CW'(do_take);
      cnt_next = cnt + (CW+1)'(do_take)
                     - (CW+1)'(do_rel);
    end
  end

  always_comb begin
    fl_pop = '0;
    for (int b = 0; b < NUM_PHYREGS; b++)
      fl_pop = fl_pop + FCW'(fl_next[b]);
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      fl <= RESET_FL;
      rfl <= RESET_FL;
      head <= '0;
      tail <= '0;
      cnt <= '0;
      free_count <= FCW'(NUM_PHYREGS - NUM_LOGREGS);
      for (int i = 0; i < NUM_CKPT; i++)
        amask[i] <= '0;
    end else begin
      fl <= fl_next;
      rfl <= rfl_next;
      head <= head_next;
      tail <= tail_next;
      cnt <= cnt_next;
      free_count <= fl_pop;
      for (int i = 0; i < NUM_CKPT; i++) begin
        if (!kill) begin
          if (do_take && CW'(i) == tail)
            amask[i] <= '0;
          else if (live[i])
            amask[i] <= amask[i] | alloc_mask;
        end
      end
    end
  end

endmodule

// File: tb/tb_checkpoint_free_list.sv
// Vector table plus scoreboard bench for the
// checkpointed free list.
module tb_checkpoint_free_list;

  logic clock = 1'b0;
  logic reset = 1'b1;
  always #5 clock = ~clock;

  logic [6:0] available_prd [4];
  logic [3:0] available_valid;
  logic [3:0] prd_used;
  logic [3:0] committed_rd_valid;
  logic [6:0] committed_phyreg [4];
  logic [6:0] committed_prev_phyreg [4];
  logic       ckpt_take;
  logic [2:0] ckpt_id;
  logic       ckpt_full;
  logic       ckpt_release;
  logic       ckpt_restore;
  logic [2:0] ckpt_restore_id;
  logic       flush_in;
  logic [6:0] free_count;

  checkpoint_free_list dut (
    .clock                 (clock),
    .reset                 (reset),
    .available_prd         (available_prd),
    .available_valid       (available_valid),
    .prd_used              (prd_used),
    .committed_rd_valid    (committed_rd_valid),
    .committed_phyreg      (committed_phyreg),
    .committed_prev_phyreg (committed_prev_phyreg),
    .ckpt_take             (ckpt_take),
    .ckpt_id               (ckpt_id),
    .ckpt_full             (ckpt_full),
    .ckpt_release          (ckpt_release),
    .ckpt_restore          (ckpt_restore),
    .ckpt_restore_id       (ckpt_restore_id),
    .flush_in              (flush_in),
    .free_count            (free_count)
  );

  typedef struct {
    logic [3:0] used;
    logic       take, rel, rsto;
    logic [2:0] rid;
    logic       flush, cv;
    logic [6:0] cphy, cprev;
    logic [6:0] eprd [4];
    logic [3:0] ev;
    logic [2:0] eid;
    logic       efull;
    logic [6:0] efc;
  } vec_t;

  vec_t tbl [$];
  vec_t sb [$];
  logic [6:0] fq [$];
  int checks = 0;
  int errors = 0;
  int step = 0;

  function automatic vec_t mk(
    logic [3:0] used, logic take, logic rel,
    logic rsto, logic [2:0] rid, logic flush,
    logic cv, logic [6:0] cphy, logic [6:0] cprev,
    logic [6:0] p0, logic [6:0] p1,
    logic [6:0] p2, logic [6:0] p3,
    logic [3:0] ev, logic [2:0] eid,
    logic efull, logic [6:0] efc);
    vec_t v;
    v.used = used; v.take = take; v.rel = rel;
    v.rsto = rsto; v.rid = rid; v.flush = flush;
    v.cv = cv; v.cphy = cphy; v.cprev = cprev;
    v.eprd[0] = p0; v.eprd[1] = p1;
    v.eprd[2] = p2; v.eprd[3] = p3;
    v.ev = ev; v.eid = eid;
    v.efull = efull; v.efc = efc;
    return v;
  endfunction

  task automatic cmp(string n, logic [31:0] a,
                     logic [31:0] e);
    checks++;
    if (a !== e) begin
      errors++;
      $display("FAIL step %0d %s: got %0d expected %0d",
               step, n, a, e);
    end
  endtask

  task automatic idle_inputs();
    prd_used = '0;
    committed_rd_valid = '0;
    for (int s = 0; s < 4; s++) begin
      committed_phyreg[s] = '0;
      committed_prev_phyreg[s] = '0;
    end
    ckpt_take = 1'b0;
    ckpt_release = 1'b0;
    ckpt_restore = 1'b0;
    ckpt_restore_id = '0;
    flush_in = 1'b0;
  endtask

  task automatic check_pop();
    vec_t e;
    e = sb.pop_front();
    cmp("valid", 32'(available_valid), 32'(e.ev));
    for (int s = 0; s < 4; s++) begin
      cmp($sformatf("prd%0d", s),
          32'(available_prd[s]), 32'(e.eprd[s]));
      if (available_valid[s])
        cmp("p0_offered",
            32'(available_prd[s] != 7'd0), 32'd1);
    end
    cmp("ckpt_id", 32'(ckpt_id), 32'(e.eid));
    cmp("ckpt_full", 32'(ckpt_full), 32'(e.efull));
    cmp("free_count", 32'(free_count), 32'(e.efc));
  endtask

  task automatic apply(input vec_t v);
    @(negedge clock);
    idle_inputs();
    prd_used = v.used;
    ckpt_take = v.take;
    ckpt_release = v.rel;
    ckpt_restore = v.rsto;
    ckpt_restore_id = v.rid;
    flush_in = v.flush;
    committed_rd_valid[0] = v.cv;
    committed_phyreg[0] = v.cphy;
    committed_prev_phyreg[0] = v.cprev;
    sb.push_back(v);
    #1;
    check_pop();
    step++;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  initial begin
    idle_inputs();
    // used,tk,rl,rs,rid,fl,cv,phy,prev, prd x4, valid,id,full,fc
    tbl.push_back(mk(0,0,0,0,0,0,0,0,0, 32,33,34,35, 15,0,0,64));
    tbl.push_back(mk(5,0,0,0,0,0,0,0,0, 32,33,34,35, 15,0,0,64));
    tbl.push_back(mk(0,0,0,0,0,0,0,0,0, 33,35,36,37, 15,0,0,62));
    tbl.push_back(mk(0,1,0,0,0,0,0,0,0, 33,35,36,37, 15,0,0,62));
    tbl.push_back(mk(12,0,0,0,0,0,0,0,0, 33,35,36,37, 15,1,0,62));
    tbl.push_back(mk(0,0,0,1,0,0,0,0,0, 33,35,38,39, 0,1,0,60));
    tbl.push_back(mk(1,1,0,0,0,0,0,0,0, 33,35,36,37, 15,0,0,62));
    tbl.push_back(mk(1,1,0,0,0,0,0,0,0, 35,36,37,38, 15,1,0,61));
    tbl.push_back(mk(1,1,0,0,0,0,0,0,0, 36,37,38,39, 15,2,0,60));
    tbl.push_back(mk(1,0,0,0,0,0,0,0,0, 37,38,39,40, 15,3,0,59));
    tbl.push_back(mk(0,0,0,1,1,0,0,0,0, 38,39,40,41, 0,3,0,58));
    tbl.push_back(mk(0,0,0,1,0,0,0,0,0, 36,37,38,39, 0,1,0,60));
    tbl.push_back(mk(0,1,0,0,0,0,0,0,0, 35,36,37,38, 15,0,0,61));
    tbl.push_back(mk(0,1,1,0,0,0,0,0,0, 35,36,37,38, 15,1,0,61));
    tbl.push_back(mk(0,0,1,0,0,0,0,0,0, 35,36,37,38, 15,2,0,61));
    tbl.push_back(mk(1,0,1,0,0,0,0,0,0, 35,36,37,38, 15,2,0,61));
    tbl.push_back(mk(0,1,0,0,0,0,0,0,0, 36,37,38,39, 15,2,0,60));
    tbl.push_back(mk(3,0,0,0,0,0,0,0,0, 36,37,38,39, 15,3,0,60));
    tbl.push_back(mk(0,0,0,1,2,0,1,33,10, 38,39,40,41, 0,3,0,58));
    tbl.push_back(mk(1,0,0,0,0,0,0,0,0, 10,36,37,38, 15,2,0,61));
    tbl.push_back(mk(1,0,0,0,0,0,1,10,12, 36,37,38,39, 15,2,0,60));
    tbl.push_back(mk(0,0,0,0,0,0,0,0,0, 12,37,38,39, 15,2,0,60));
    tbl.push_back(mk(1,1,0,0,0,1,1,40,5, 12,37,38,39, 0,2,0,60));
    tbl.push_back(mk(0,0,0,0,0,0,0,0,0, 5,12,32,34, 15,0,0,64));

    repeat (2) @(negedge clock);
    reset = 1'b0;
    for (int i = 0; i < tbl.size(); i++)
      apply(tbl[i]);

    // Registers left free after the flush, ascending.
    fq.push_back(7'd5);
    fq.push_back(7'd12);
    fq.push_back(7'd32);
    for (int i = 34; i < 96; i++)
      if (i != 40) fq.push_back(7'(i));

    for (int k = 0; k < 15; k++) begin
      apply(mk(15,0,0,0,0,0,0,0,0,
               fq[0], fq[1], fq[2], fq[3],
               15, 0, 0, 7'(64 - 4 * k)));
      repeat (4) void'(fq.pop_front());
    end
    apply(mk(3,0,0,0,0,0,0,0,0,
             fq[0], fq[1], fq[2], fq[3], 15,0,0,4));
    repeat (2) void'(fq.pop_front());

    for (int k = 0; k < 8; k++)
      apply(mk(0,1,0,0,0,0,0,0,0,
               fq[0], fq[1], 0, 0, 3, 3'(k), 0, 2));
    apply(mk(0,1,0,0,0,0,0,0,0, 94,95,0,0, 3,0,1,2));
    apply(mk(0,0,1,0,0,0,0,0,0, 94,95,0,0, 3,0,1,2));
    apply(mk(0,0,0,0,0,0,0,0,0, 94,95,0,0, 3,0,0,2));

    @(negedge clock);
    idle_inputs();
    reset = 1'b1;
    @(negedge clock);
    reset = 1'b0;
    apply(mk(0,0,0,0,0,0,0,0,0, 32,33,34,35, 15,0,0,64));

    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

endmodule
